// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the level-reporting bypass FIFO.
//   MAX_ADDR_WIDTH  - widest supported address (pointers are one bit wider)
//   DEF_ADDR_WIDTH  - default address width of the FIFO
//   DEPTH           - word capacity at the default address width
//   fifo_ptr_t      - pointer container wide enough for any legal ADDR_WIDTH
//   fifo_level()    - modular write/read pointer distance for a given width
package fifo_pkg;

  localparam int unsigned MAX_ADDR_WIDTH = 32'd10;
  localparam int unsigned DEF_ADDR_WIDTH = 32'd4;
  localparam int unsigned DEPTH          = 32'd1 << DEF_ADDR_WIDTH;

  typedef logic [MAX_ADDR_WIDTH:0] fifo_ptr_t;

  // Pointers are aw+1 bits and wrap naturally, so the fill level is the
  // difference taken modulo 2**(aw+1). Inputs arrive zero-extended into the
  // wide container; the mask drops the borrow bits above the real width.
  function automatic fifo_ptr_t fifo_level(input fifo_ptr_t   wr,
                                           input fifo_ptr_t   rd,
                                           input int unsigned aw);
    fifo_ptr_t mask;
    mask = (fifo_ptr_t'(1'b1) << (aw + 32'd1)) - fifo_ptr_t'(1'b1);
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctl.sv
// fifo_ptr_ctl: pointer, level and sticky error-flag control for the FIFO.
//   clk_i, rst_ni     - clock, asynchronous active-low reset
//   flush             - synchronous clear of pointers and flags (wins over all)
//   push, pull        - raw requests from producer / consumer
//   bypass            - word is being forwarded around storage this cycle
//   empty_ext         - empty as seen by the consumer (after bypass mux)
//   wr_en             - store data_in at waddr on this edge
//   waddr, raddr      - storage indices (low bits of the pointers)
//   level             - stored word count 0..2**ADDR_WIDTH
//   full, empty_int   - storage full / storage empty
//   overflow          - sticky: push rejected because full
//   underflow         - sticky: pull found no data
module fifo_ptr_ctl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pull,
  input  logic                  bypass,
  input  logic                  empty_ext,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty_int,
  output logic                  overflow,
  output logic                  underflow
);

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t PTR_ONE   = ptr_t'(1'b1);
  localparam ptr_t DEPTH_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};

  ptr_t wrptr_q, wrptr_d;
  ptr_t rdptr_q, rdptr_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  logic rd_en_s;
  logic ovf_set_s;
  logic udf_set_s;

  // Level and status decode from the registered pointers only.
  always_comb begin
    level     = ptr_t'(fifo_level(fifo_ptr_t'(wrptr_q), fifo_ptr_t'(rdptr_q), ADDR_WIDTH));
    full      = (level == DEPTH_LVL);
    empty_int = (level == ptr_t'(1'b0));
  end

  // Request qualification. full is the registered view, so a same-cycle pull
  // never makes room for a push. A bypassed pull is served by data_in and is
  // therefore never an underflow, even when the producer is idle.
  always_comb begin
    wr_en     = push & ~full & ~bypass & ~flush;
    rd_en_s   = pull & ~empty_int & ~flush;
    ovf_set_s = push & full & ~flush;
    udf_set_s = pull & empty_ext & ~bypass & ~flush;
  end

  // Next-state for pointers and sticky flags; flush clears everything.
  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (flush) begin
      wrptr_d = '0;
      rdptr_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_en) begin
        wrptr_d = wrptr_q + PTR_ONE;
      end else begin
        wrptr_d = wrptr_q;
      end
      if (rd_en_s) begin
        rdptr_d = rdptr_q + PTR_ONE;
      end else begin
        rdptr_d = rdptr_q;
      end
      ovf_d = ovf_q | ovf_set_s;
      udf_d = udf_q | udf_set_s;
    end
  end

  // Pointer and flag registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign waddr     = wrptr_q[ADDR_WIDTH-1:0];
  assign raddr     = rdptr_q[ADDR_WIDTH-1:0];
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: rtl/sync_bypass_fifo_lvl.sv
// sync_bypass_fifo_lvl: single-clock show-ahead FIFO with fill level,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// and an optional combinational pass-thru path when the FIFO is empty.
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   flush              - synchronous clear of pointers and error flags
//   data_in, push      - write port; full reports 2**ADDR_WIDTH words held
//   data_out, pull     - show-ahead read port; empty = nothing for consumer
//   level              - stored word count
//   af_thresh/ae_thresh- thresholds for almost_full / almost_empty
//   overflow/underflow - sticky error flags
// With PASS_THRU=1 a pull on empty storage forwards data_in to data_out in
// the same cycle (push->empty and data_in->data_out are combinational);
// downstream logic must register these.
module sync_bypass_fifo_lvl
  import fifo_pkg::*;
#(
  parameter bit          PASS_THRU  = 1'b1,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 32'd8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  pull,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH_L = 32'd1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_L];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH_L];

  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [ADDR_WIDTH-1:0] raddr_s;
  logic                  empty_int_s;
  logic                  bypass_s;
  logic                  empty_s;

  fifo_ptr_ctl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ptr_ctl (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush     (flush),
    .push      (push),
    .pull      (pull),
    .bypass    (bypass_s),
    .empty_ext (empty_s),
    .wr_en     (wr_en_s),
    .waddr     (waddr_s),
    .raddr     (raddr_s),
    .level     (level),
    .full      (full),
    .empty_int (empty_int_s),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Bypass selection and consumer-side empty/data mux. Flush suppresses the
  // bypass so nothing is delivered in a flush cycle.
  always_comb begin
    if (PASS_THRU) begin
      bypass_s = pull & empty_int_s & ~flush;
    end else begin
      bypass_s = 1'b0;
    end
    if (bypass_s) begin
      empty_s  = ~push;
      data_out = data_in;
    end else begin
      empty_s  = empty_int_s;
      data_out = mem_q[raddr_s];
    end
  end

  assign empty = empty_s;

  // Threshold flags depend only on registered pointers and threshold inputs.
  always_comb begin
    almost_full  = (level >= af_thresh);
    almost_empty = (level <= ae_thresh);
  end

  // Storage next-state: one word written per accepted push.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_s) begin
      mem_d[waddr_s] = data_in;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage array; contents deliberately survive reset and flush.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_sync_bypass_fifo_lvl.sv
// Self-checking bench: a PASS_THRU=1 instance carries the main sequence and a
// PASS_THRU=0 instance covers store-only behaviour. Expected words live in
// per-instance scoreboard queues.
module tb_sync_bypass_fifo_lvl;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned DEP = 4;

  logic          clk_i;
  logic          rst_ni;
  logic [AW:0]   af_thresh;
  logic [AW:0]   ae_thresh;

  // pass-thru instance
  logic          flush, push, pull;
  logic [DW-1:0] data_in, data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   level;

  // store-mode instance
  logic          s_flush, s_push, s_pull;
  logic [DW-1:0] s_din, s_dout;
  logic          s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic [AW:0]   s_level;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] sq[$];
  logic          m_ovf = 1'b0;
  logic          s_m_ovf = 1'b0;
  logic          s_m_udf = 1'b0;

  sync_bypass_fifo_lvl #(.PASS_THRU(1'b1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush(flush), .data_in(data_in), .push(push),
    .full(full), .data_out(data_out), .pull(pull), .empty(empty), .level(level),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  sync_bypass_fifo_lvl #(.PASS_THRU(1'b0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_st (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush(s_flush), .data_in(s_din), .push(s_push),
    .full(s_full), .data_out(s_dout), .pull(s_pull), .empty(s_empty), .level(s_level),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(s_afull),
    .almost_empty(s_aempty), .overflow(s_ovf), .underflow(s_udf)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Idle-input checks of the pass-thru instance against the scoreboard.
  task automatic post_chk();
    check_val("level", 32'(level), 32'(mq.size()));
    check_val("full", 32'(full), 32'(mq.size() == DEP));
    check_val("empty", 32'(empty), 32'(mq.size() == 0));
    check_val("almost_full", 32'(almost_full), 32'(mq.size() >= int'(af_thresh)));
    check_val("almost_empty", 32'(almost_empty), 32'(mq.size() <= int'(ae_thresh)));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    check_val("underflow", 32'(underflow), 32'd0);
    if (mq.size() != 0) check_val("show_ahead", 32'(data_out), 32'(mq[0]));
  endtask

  // One cycle on the pass-thru instance; called at posedge+1.
  task automatic cyc(input logic p, input logic q, input logic [DW-1:0] d);
    logic byp, full_pre;
    push = p; pull = q; data_in = d;
    #1;
    byp = q && (mq.size() == 0);
    full_pre = (mq.size() == DEP);
    if (byp) begin
      check_val("byp_empty", 32'(empty), 32'(!p));
      if (p) check_val("byp_data", 32'(data_out), 32'(d));
    end else if (q) begin
      check_val("pull_empty", 32'(empty), 32'd0);
      check_val("pull_head", 32'(data_out), 32'(mq[0]));
    end
    if (p && full_pre) m_ovf = 1'b1;
    if (q && !byp) void'(mq.pop_front());
    if (p && !full_pre && !byp) mq.push_back(d);
    @(posedge clk_i); #1;
    push = 1'b0; pull = 1'b0;
    #1;
    post_chk();
  endtask

  // Flush cycle on the pass-thru instance with arbitrary push/pull.
  task automatic do_flush(input logic p, input logic q, input logic [DW-1:0] d);
    flush = 1'b1; push = p; pull = q; data_in = d;
    #1;
    check_val("flush_no_bypass", 32'(empty), 32'(mq.size() == 0));
    @(posedge clk_i); #1;
    flush = 1'b0; push = 1'b0; pull = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    #1;
    post_chk();
  endtask

  // One cycle on the store-mode instance; called at posedge+1.
  task automatic scyc(input logic p, input logic q, input logic [DW-1:0] d);
    logic full_pre;
    s_push = p; s_pull = q; s_din = d;
    #1;
    check_val("st_empty_comb", 32'(s_empty), 32'(sq.size() == 0));
    if (q && sq.size() != 0) check_val("st_head", 32'(s_dout), 32'(sq[0]));
    full_pre = (sq.size() == DEP);
    if (p && full_pre) s_m_ovf = 1'b1;
    if (q && sq.size() == 0) s_m_udf = 1'b1;
    if (q && sq.size() != 0) void'(sq.pop_front());
    if (p && !full_pre) sq.push_back(d);
    @(posedge clk_i); #1;
    s_push = 1'b0; s_pull = 1'b0;
    #1;
    check_val("st_level", 32'(s_level), 32'(sq.size()));
    check_val("st_full", 32'(s_full), 32'(sq.size() == DEP));
    check_val("st_overflow", 32'(s_ovf), 32'(s_m_ovf));
    check_val("st_underflow", 32'(s_udf), 32'(s_m_udf));
  endtask

  initial begin
    rst_ni = 1'b0;
    af_thresh = 3'd3; ae_thresh = 3'd1;
    flush = 1'b0; push = 1'b0; pull = 1'b0; data_in = 8'h00;
    s_flush = 1'b0; s_push = 1'b0; s_pull = 1'b0; s_din = 8'h00;

    // reset state
    #2;
    post_chk();
    check_val("st_reset_level", 32'(s_level), 32'd0);
    check_val("st_reset_empty", 32'(s_empty), 32'd1);
    af_thresh = 3'd0;
    #1;
    check_val("reset_af_zero", 32'(almost_full), 32'd1);
    af_thresh = 3'd3;
    #9;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // fill, overflow, drain
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i));
    cyc(1'b1, 1'b0, 8'hA5);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h00);

    // bypass on empty, then idle pull without underflow
    cyc(1'b1, 1'b1, 8'h5C);
    cyc(1'b0, 1'b1, 8'h00);

    // concurrent push/pull at level 2, wrapping the pointers
    cyc(1'b1, 1'b0, 8'hB0);
    cyc(1'b1, 1'b0, 8'hB1);
    cyc(1'b1, 1'b1, 8'h33);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 8'(8'h40 + i));
    while (mq.size() != 0) cyc(1'b0, 1'b1, 8'h00);

    // flush from full with overflow set; pushed word must not be stored
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
    do_flush(1'b1, 1'b1, 8'hEE);
    cyc(1'b1, 1'b0, 8'h42);
    cyc(1'b0, 1'b1, 8'h00);

    // store-mode instance: fill, overflow, drain, underflow, no bypass
    for (int i = 1; i <= 5; i++) scyc(1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 4; i++) scyc(1'b0, 1'b1, 8'h00);
    scyc(1'b0, 1'b1, 8'h00);
    s_flush = 1'b1;
    @(posedge clk_i); #1;
    s_flush = 1'b0;
    sq.delete(); s_m_ovf = 1'b0; s_m_udf = 1'b0;
    #1;
    check_val("st_flush_udf", 32'(s_udf), 32'd0);
    check_val("st_flush_ovf", 32'(s_ovf), 32'd0);
    scyc(1'b1, 1'b1, 8'h77);
    scyc(1'b0, 1'b1, 8'h00);

    // asynchronous reset mid-stream at level 3
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'hD0 + i));
    scyc(1'b1, 1'b0, 8'h99);
    rst_ni = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0;
    post_chk();
    check_val("st_rst_level", 32'(s_level), 32'd0);
    check_val("st_rst_udf", 32'(s_udf), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    sq.delete(); s_m_ovf = 1'b0; s_m_udf = 1'b0;
    cyc(1'b1, 1'b0, 8'h11);
    cyc(1'b0, 1'b1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
